// File: rtl/lc3_control_fsm.sv
// SLC-3 instruction sequencer: Moore fetch/decode/execute FSM with a parameterised memory wait.
// Control outputs are registered from the decode of the next state, so they line up with the state register.
`timescale 1ns/1ps
module lc3_control_fsm #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       DRMUX,
  output logic       MIO_EN,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  localparam int unsigned CW = 4;

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32, S1, S5, S9, S0, S22, S12,
    S4, S21, S6, S7, S25, S27, S23, S16, P1, P2
  } state_t;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic       ld_led;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       sr1mux;
    logic       sr2mux;
    logic       drmux;
    logic       mio_en;
    logic [1:0] aluk;
    logic       mem_oe;
    logic       mem_we;
  } ctl_t;

  state_t          state, nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  ctl_t            ctl_q, ctl_d;
  logic            wait_done;

  assign wait_done = (cnt == CW'(MEM_WAIT - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= HALTED;
      cnt   <= '0;
      ctl_q <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      ctl_q <= ctl_d;
    end
  end

  always_comb begin
    nxt     = state;
    cnt_nxt = '0;
    ctl_d   = '0;

    case (state)
      HALTED:  if (Run) nxt = S18;
      S18:     nxt = S33;
      S33:     if (wait_done) nxt = S35;
      S35:     nxt = S32;
      S32: begin
        case (Opcode)
          4'b0001: nxt = S1;
          4'b0101: nxt = S5;
          4'b1001: nxt = S9;
          4'b0000: nxt = S0;
          4'b1100: nxt = S12;
          4'b0100: nxt = S4;
          4'b0110: nxt = S6;
          4'b0111: nxt = S7;
          4'b1101: nxt = P1;
          default: nxt = S18;
        endcase
      end
      S1, S5, S9, S22, S12, S21, S27: nxt = S18;
      S0:      nxt = BEN ? S22 : S18;
      S4:      nxt = S21;
      S6:      nxt = S25;
      S7:      nxt = S23;
      S25:     if (wait_done) nxt = S27;
      S23:     nxt = S16;
      S16:     if (wait_done) nxt = S18;
      P1:      if (Continue) nxt = P2;
      P2:      if (!Continue) nxt = S18;
      default: nxt = HALTED;
    endcase

    // Counter runs only while a wait state is held; any entry restarts it at zero.
    if (nxt == state && (state == S33 || state == S25 || state == S16))
      cnt_nxt = cnt + CW'(1);

    case (nxt)
      S18: begin
        ctl_d.gate_pc = 1'b1;
        ctl_d.ld_mar  = 1'b1;
        ctl_d.ld_pc   = 1'b1;
      end
      S33, S25: begin
        ctl_d.mem_oe = 1'b1;
        ctl_d.mio_en = 1'b1;
        ctl_d.ld_mdr = 1'b1;
      end
      S35: begin
        ctl_d.gate_mdr = 1'b1;
        ctl_d.ld_ir    = 1'b1;
      end
      S32: ctl_d.ld_ben = 1'b1;
      S1, S5, S9: begin
        ctl_d.sr1mux   = 1'b1;
        ctl_d.sr2mux   = (nxt == S9) ? 1'b0 : IR_5;
        ctl_d.aluk     = (nxt == S1) ? 2'b00 : (nxt == S5) ? 2'b01 : 2'b10;
        ctl_d.gate_alu = 1'b1;
        ctl_d.ld_reg   = 1'b1;
        ctl_d.ld_cc    = 1'b1;
      end
      S22, S21: begin
        ctl_d.addr2mux = (nxt == S22) ? 2'b10 : 2'b11;
        ctl_d.pcmux    = 2'b10;
        ctl_d.ld_pc    = 1'b1;
      end
      S12: begin
        ctl_d.sr1mux   = 1'b1;
        ctl_d.addr1mux = 1'b1;
        ctl_d.pcmux    = 2'b10;
        ctl_d.ld_pc    = 1'b1;
      end
      S4: begin
        ctl_d.gate_pc = 1'b1;
        ctl_d.drmux   = 1'b1;
        ctl_d.ld_reg  = 1'b1;
      end
      S6, S7: begin
        ctl_d.sr1mux      = 1'b1;
        ctl_d.addr1mux    = 1'b1;
        ctl_d.addr2mux    = 2'b01;
        ctl_d.gate_marmux = 1'b1;
        ctl_d.ld_mar      = 1'b1;
      end
      S27: begin
        ctl_d.gate_mdr = 1'b1;
        ctl_d.ld_reg   = 1'b1;
        ctl_d.ld_cc    = 1'b1;
      end
      S23: begin
        ctl_d.aluk     = 2'b11;
        ctl_d.gate_alu = 1'b1;
        ctl_d.ld_mdr   = 1'b1;
      end
      S16:     ctl_d.mem_we = 1'b1;
      P1:      ctl_d.ld_led = 1'b1;
      default: ctl_d = '0;
    endcase
  end

  assign LD_MAR     = ctl_q.ld_mar;
  assign LD_MDR     = ctl_q.ld_mdr;
  assign LD_IR      = ctl_q.ld_ir;
  assign LD_BEN     = ctl_q.ld_ben;
  assign LD_CC      = ctl_q.ld_cc;
  assign LD_REG     = ctl_q.ld_reg;
  assign LD_PC      = ctl_q.ld_pc;
  assign LD_LED     = ctl_q.ld_led;
  assign GatePC     = ctl_q.gate_pc;
  assign GateMDR    = ctl_q.gate_mdr;
  assign GateALU    = ctl_q.gate_alu;
  assign GateMARMUX = ctl_q.gate_marmux;
  assign PCMUX      = ctl_q.pcmux;
  assign ADDR1MUX   = ctl_q.addr1mux;
  assign ADDR2MUX   = ctl_q.addr2mux;
  assign SR1MUX     = ctl_q.sr1mux;
  assign SR2MUX     = ctl_q.sr2mux;
  assign DRMUX      = ctl_q.drmux;
  assign MIO_EN     = ctl_q.mio_en;
  assign ALUK       = ctl_q.aluk;
  assign Mem_OE     = ctl_q.mem_oe;
  assign Mem_WE     = ctl_q.mem_we;

endmodule
